fft_frame_ctrl: RTL

//  Frame sequencer in front of the 512-point FFT_Fixed datapath. Reads one buffered 512-sample frame

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_out_tracker.sv | 90 +++++++++
 rtl/fft_frame_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame controller and its output tracker.
// Optional error checking is enabled by defining FFT_FRAME_CTRL_ERR_EN.
package fft_pkg;

  localparam int N_POINT    = 512;
  localparam int ARRAY_IN   = 16;
  localparam int BLK_CNT    = N_POINT / ARRAY_IN;
  localparam int BLK_IDX_W  = $clog2(BLK_CNT);
  localparam int INFLIGHT_W = 3;

  localparam logic [BLK_IDX_W-1:0] LAST_BLK = BLK_IDX_W'(BLK_CNT - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_out_tracker.sv
// Counts FFT output blocks, flags first/last blocks and pulses frame_done after each frame.
// With FFT_FRAME_CTRL_ERR_EN defined it also keeps sticky gap/orphan error flags.
module fft_out_tracker
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fft_do_en,
  input  logic                 inflight_zero,
  input  logic                 err_clr,
  output logic [BLK_IDX_W-1:0] out_blk_idx,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 err_gap,
  output logic                 err_orphan
);

  logic [BLK_IDX_W-1:0] cnt_reg;
  logic [BLK_IDX_W-1:0] cnt_next;
  logic                 frame_done_reg;
  logic                 cnt_adv;

`ifdef FFT_FRAME_CTRL_ERR_EN
  // An orphan beat has no frame to belong to, so it must not move the block index.
  assign cnt_adv = fft_do_en && !inflight_zero;
`else
  assign cnt_adv = fft_do_en;
`endif

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_adv) begin
      cnt_next = (cnt_reg == LAST_BLK) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      frame_done_reg <= out_last;
    end
  end

  assign out_blk_idx = cnt_reg;
  assign out_first   = fft_do_en && (cnt_reg == '0);
  assign out_last    = fft_do_en && (cnt_reg == LAST_BLK);
  assign frame_done  = frame_done_reg;

`ifdef FFT_FRAME_CTRL_ERR_EN
  logic err_gap_reg;
  logic err_orphan_reg;
  logic gap_set;
  logic orphan_set;

  assign gap_set    = !fft_do_en && (cnt_reg != '0);
  assign orphan_set = fft_do_en && inflight_zero;

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_gap_reg    <= 1'b0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (gap_set) begin
        err_gap_reg <= 1'b1;
      end else if (err_clr) begin
        err_gap_reg <= 1'b0;
      end
      if (orphan_set) begin
        err_orphan_reg <= 1'b1;
      end else if (err_clr) begin
        err_orphan_reg <= 1'b0;
      end
    end
  end

  assign err_gap    = err_gap_reg;
  assign err_orphan = err_orphan_reg;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, inflight_zero};
  assign err_gap    = 1'b0;
  assign err_orphan = 1'b0;
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of the 512-point FFT: reads frames as 32 blocks, tracks frames in flight.
// Optional error checking in the output tracker is enabled by defining FFT_FRAME_CTRL_ERR_EN.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  frame_avail,
  output logic                  frame_taken,
  output logic                  buf_rd_en,
  output logic [BLK_IDX_W-1:0]  buf_rd_addr,
  output logic                  fft_din_valid,
  input  logic                  fft_do_en,
  output logic [BLK_IDX_W-1:0]  out_blk_idx,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  busy,
  input  logic                  err_clr,
  output logic                  err_gap,
  output logic                  err_orphan
);

  localparam logic [INFLIGHT_W-1:0] MAX_INF = INFLIGHT_W'(MAX_INFLIGHT);

  fft_ctrl_state_t       state_reg;
  fft_ctrl_state_t       state_next;
  logic [BLK_IDX_W-1:0]  addr_reg;
  logic [BLK_IDX_W-1:0]  addr_next;
  logic [INFLIGHT_W-1:0] inflight_reg;
  logic [INFLIGHT_W-1:0] inflight_next;
  logic                  can_start;
  logic                  issue;
  logic                  trk_out_last;
  logic                  rd_pipe_reg [RD_LAT];

  // During the last block the current frame is already counted, so the same test
  // decides both a fresh start from IDLE and a back-to-back continuation.
  assign can_start = enable && frame_avail && (inflight_reg < MAX_INF);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (can_start) begin
          state_next = LOAD;
          addr_next  = '0;
        end
      end
      LOAD: begin
        if (addr_reg == LAST_BLK) begin
          addr_next = '0;
          if (!can_start) begin
            state_next = IDLE;
          end
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  assign buf_rd_en   = (state_reg == LOAD);
  assign buf_rd_addr = addr_reg;
  assign frame_taken = buf_rd_en && (addr_reg == LAST_BLK);
  assign issue       = buf_rd_en && (addr_reg == '0);

  always_comb begin
    inflight_next = inflight_reg;
    case ({issue, trk_out_last})
      2'b10: if (inflight_reg < MAX_INF) inflight_next = inflight_reg + 1'b1;
      2'b01: if (inflight_reg != '0) inflight_next = inflight_reg - 1'b1;
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;
  assign busy     = (state_reg != IDLE) || (inflight_reg != '0);

  // Read-latency pipe: din_valid follows the read strobe by RD_LAT cycles.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          rd_pipe_reg[gi] <= buf_rd_en;
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign fft_din_valid = rd_pipe_reg[RD_LAT-1];

  fft_out_tracker u_out_tracker (
    .clk           (clk),
    .rstn          (rstn),
    .fft_do_en     (fft_do_en),
    .inflight_zero (inflight_reg == '0),
    .err_clr       (err_clr),
    .out_blk_idx   (out_blk_idx),
    .out_first     (out_first),
    .out_last      (trk_out_last),
    .frame_done    (frame_done),
    .err_gap       (err_gap),
    .err_orphan    (err_orphan)
  );

  assign out_last = trk_out_last;

endmodule
